// File: rtl/gbdt_feat_pkg.sv
// Shared constants and types for the GBDT ping-pong feature store.
// Modules take these as parameter defaults and re-derive their own sizes.
package gbdt_feat_pkg;

    localparam int FEAT_W    = 9;
    localparam int NUM_FEATS = 256;
    localparam int DMA_RATE  = 144;
    localparam int NUM_RD    = 8;

    localparam int LANES = DMA_RATE / FEAT_W;
    localparam int BEATS = (NUM_FEATS + LANES - 1) / LANES;
    localparam int IDX_W = $clog2(NUM_FEATS);

    typedef logic [FEAT_W-1:0] feat_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FREE = 2'd1,
        LOAD      = 2'd2
    } load_state_t;

endpackage

// File: rtl/feature_bank.sv
// One sample's worth of feature storage.
// Writes arrive one DMA beat at a time; reads are NUM_RD combinational lookups.
module feature_bank #(
    parameter int FEAT_W    = 9,
    parameter int NUM_FEATS = 256,
    parameter int LANES     = 16,
    parameter int NUM_RD    = 8,
    parameter int IDX_W     = 8,
    parameter int BEAT_W    = 5
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [BEAT_W-1:0]        beat_idx,
    input  logic [LANES*FEAT_W-1:0]  wdata,
    input  logic [NUM_RD*IDX_W-1:0]  rd_idx,
    output logic [NUM_RD*FEAT_W-1:0] rd_data
);

    logic [FEAT_W-1:0] mem [NUM_FEATS];

    // Lanes past the end of the sample (partial last beat) are dropped.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int j = 0; j < LANES; j++) begin
                if (int'(beat_idx) * LANES + j < NUM_FEATS) begin
                    mem[IDX_W'(int'(beat_idx) * LANES + j)] <= wdata[j*FEAT_W +: FEAT_W];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [IDX_W-1:0] idx;
            assign idx = rd_idx[gi*IDX_W +: IDX_W];
            assign rd_data[gi*FEAT_W +: FEAT_W] = (int'(idx) < NUM_FEATS) ? mem[idx] : '0;
        end
    endgenerate

endmodule

// File: rtl/input_features_pp.sv
// Double-buffered feature store: DMA beats fill one bank while lookups read the
// other; the two banks behave as a 2-entry in-order sample FIFO.
module input_features_pp
    import gbdt_feat_pkg::*;
#(
    parameter int FEAT_W    = gbdt_feat_pkg::FEAT_W,
    parameter int NUM_FEATS = gbdt_feat_pkg::NUM_FEATS,
    parameter int DMA_RATE  = gbdt_feat_pkg::DMA_RATE,
    parameter int NUM_RD    = gbdt_feat_pkg::NUM_RD,
    localparam int IDX_W    = $clog2(NUM_FEATS)
) (
    input  logic                     gbdt_clk,
    input  logic                     gbdt_rst,
    input  logic                     start,
    input  logic [DMA_RATE-1:0]      dma_data,
    input  logic                     dma_valid,
    output logic                     dma_ready,
    output logic                     load_done,
    output logic                     start_err,
    output logic                     sample_valid,
    input  logic                     sample_release,
    input  logic [NUM_RD*IDX_W-1:0]  features_nums,
    output logic [NUM_RD*FEAT_W-1:0] features_vals,
    output logic                     idx_err
);

    localparam int LANES = DMA_RATE / FEAT_W;
    localparam int BEATS = (NUM_FEATS + LANES - 1) / LANES;
    localparam int CNT_W = $clog2(BEATS + 1);

    load_state_t      state_reg, state_next;
    logic [1:0]       full_reg, full_next;
    logic             wr_ptr_reg, wr_ptr_next;
    logic             rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic             load_done_reg, start_err_reg, idx_err_reg;

    logic accept, last_beat, release_ok;
    logic [NUM_RD-1:0] oor;
    logic [NUM_RD*FEAT_W-1:0] rd_bank [2];

    assign dma_ready    = (state_reg == LOAD);
    assign accept       = dma_valid && dma_ready;
    assign last_beat    = accept && (beat_cnt_reg == CNT_W'(BEATS - 1));
    assign sample_valid = full_reg[rd_ptr_reg];
    assign release_ok   = sample_release && full_reg[rd_ptr_reg];
    assign load_done    = load_done_reg;
    assign start_err    = start_err_reg;
    assign idx_err      = idx_err_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (start) state_next = full_reg[wr_ptr_reg] ? WAIT_FREE : LOAD;
            WAIT_FREE: if (!full_reg[wr_ptr_reg]) state_next = LOAD;
            LOAD:      if (last_beat) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Completion and release always target different banks, so both may apply.
    always_comb begin
        full_next     = full_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        if (accept) begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
        end
        if (last_beat) begin
            full_next[wr_ptr_reg] = 1'b1;
            wr_ptr_next           = ~wr_ptr_reg;
            beat_cnt_next         = '0;
        end
        if (release_ok) begin
            full_next[rd_ptr_reg] = 1'b0;
            rd_ptr_next           = ~rd_ptr_reg;
        end
    end

    always_ff @(posedge gbdt_clk) begin
        if (gbdt_rst) begin
            state_reg     <= IDLE;
            full_reg      <= '0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            beat_cnt_reg  <= '0;
            load_done_reg <= 1'b0;
            start_err_reg <= 1'b0;
            idx_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            full_reg      <= full_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            beat_cnt_reg  <= beat_cnt_next;
            load_done_reg <= last_beat;
            start_err_reg <= start && (state_reg != IDLE);
            idx_err_reg   <= idx_err_reg | (full_reg[rd_ptr_reg] && (|oor));
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            feature_bank #(
                .FEAT_W   (FEAT_W),
                .NUM_FEATS(NUM_FEATS),
                .LANES    (LANES),
                .NUM_RD   (NUM_RD),
                .IDX_W    (IDX_W),
                .BEAT_W   (CNT_W)
            ) u_bank (
                .clk     (gbdt_clk),
                .we      (accept && (wr_ptr_reg == 1'(gi))),
                .beat_idx(beat_cnt_reg),
                .wdata   (dma_data[LANES*FEAT_W-1:0]),
                .rd_idx  (features_nums),
                .rd_data (rd_bank[gi])
            );
        end

        // Gating on sample_valid keeps never-written storage off the outputs.
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_out
            logic [FEAT_W-1:0] val_reg;
            assign oor[gi] = int'(features_nums[gi*IDX_W +: IDX_W]) >= NUM_FEATS;
            assign features_vals[gi*FEAT_W +: FEAT_W] = val_reg;

            always_ff @(posedge gbdt_clk) begin
                if (gbdt_rst) begin
                    val_reg <= '0;
                end else if (full_reg[rd_ptr_reg] && !oor[gi]) begin
                    val_reg <= rd_ptr_reg ? rd_bank[1][gi*FEAT_W +: FEAT_W]
                                          : rd_bank[0][gi*FEAT_W +: FEAT_W];
                end else begin
                    val_reg <= '0;
                end
            end
        end
    endgenerate

endmodule

// File: doc/input_features_pp.md
Name: input_features_pp

Overview:
- Parametrised, double-buffered (ping-pong) feature store for the GBDT engine.
- Unpacks wide DMA beats into per-feature entries in one bank while the tree-evaluation logic reads the other bank through NUM_RD lookup ports.
- Sample-level handshakes expose the two banks as a 2-entry in-order sample FIFO.
- Sits between the DMA front end and the tree/node evaluation pipeline.

Parameters:
- FEAT_W, 9, bits per feature.
- NUM_FEATS, 256, features per sample.
- DMA_RATE, 144, bits per DMA beat. Must be a multiple of FEAT_W.
- NUM_RD, 8, parallel lookup ports.
- LANES (derived), DMA_RATE/FEAT_W, default 16. Features per beat.
- BEATS (derived), ceil(NUM_FEATS/LANES), default 16. Beats per sample.
- IDX_W (derived), $clog2(NUM_FEATS), default 8.

Ports:
- gbdt_clk  in  1  clock; single clock domain.
- gbdt_rst  in  1  reset, synchronous and active-high.
- start  in  1  request to load one sample.
- dma_data  in  DMA_RATE  beat; lane j = dma_data[j*FEAT_W +: FEAT_W].
- dma_valid  in  1  beat valid.
- dma_ready  out  1  beat accepted when dma_valid && dma_ready.
- load_done  out  1  one-cycle pulse, sample fully written.
- start_err  out  1  one-cycle pulse, start ignored (already loading/waiting).
- sample_valid  out  1  read bank holds a complete sample.
- sample_release  in  1  consumer finished with current sample.
- features_nums  in  NUM_RD*IDX_W  packed lookup indices.
- features_vals  out  NUM_RD*FEAT_W  packed lookup results.
- idx_err  out  1  sticky: lookup index >= NUM_FEATS seen while sample_valid.

Behaviour:
- State: full[1:0] flags, wr_ptr, rd_ptr (1 bit each), beat_cnt ($clog2(BEATS+1) bits), load FSM {IDLE, WAIT_FREE, LOAD}.
- IDLE, start=1:
  - full[wr_ptr]=0 -> LOAD.
  - full[wr_ptr]=1 -> WAIT_FREE.
- WAIT_FREE: go to LOAD in the cycle after full[wr_ptr] clears.
- start in LOAD or WAIT_FREE is ignored and pulses start_err next cycle.
- dma_ready=1 only in LOAD (registered state, no combinational path from dma_valid). dma_valid while dma_ready=0 is dropped.
- LOAD, accepted beat:
  - lane j is written to bank[wr_ptr][beat_cnt*LANES+j]; lanes with index >= NUM_FEATS are discarded.
  - beat_cnt increments.
- Last beat (beat_cnt==BEATS-1) accepted:
  - next cycle: full[wr_ptr]=1, wr_ptr toggles, beat_cnt=0, FSM IDLE, load_done=1 for one cycle.
  - First beat of a new sample can be accepted 2 cycles after last beat at the earliest (IDLE, start, LOAD).
- sample_valid = full[rd_ptr].
- sample_release with sample_valid=1: next cycle full[rd_ptr]=0, rd_ptr toggles. sample_release with sample_valid=0 is ignored.
- Same-cycle load completion and release act on different banks; both take effect.
- Release freeing the bank WAIT_FREE waits on: LOAD one cycle after the flag clears.
- Readout:
  - features_vals[i] is registered, latency 1.
  - Value = bank[rd_ptr][features_nums[i]] when sample_valid=1 and index < NUM_FEATS, else 0.
  - idx_err sets on an out-of-range index while sample_valid=1 and stays set until reset.
- Reset values:
  - FSM IDLE; pointers, full, beat_cnt = 0.
  - dma_ready, load_done, start_err, sample_valid, idx_err, features_vals = 0.
  - Bank storage is not reset; output gating guarantees no stale or X data escapes.
- Reset mid-load aborts the load; partial data is discarded and both banks are marked free.

Decomposition:
- Shared package gbdt_feat_pkg:
  - FEAT_W, NUM_FEATS, DMA_RATE, NUM_RD defaults.
  - LANES, BEATS, IDX_W derivations.
  - typedef feat_t = logic [FEAT_W-1:0].
  - enum load_state_t {IDLE, WAIT_FREE, LOAD}.
- Sub-module feature_bank: one NUM_FEATS x FEAT_W array with a LANES-wide beat write port (we, beat index) and NUM_RD combinational read ports. Instantiated twice; the parent muxes by rd_ptr and registers the outputs.

Test Plan:
- Default params, reset, start, 16 consecutive beats (beat b lane j = 16b+j) -> dma_ready high for 16 cycles, load_done pulse once, sample_valid=1; features_nums={0,15,16,100,200,254,255,1} -> features_vals equal the indices one cycle later.
- Same load with dma_valid toggling 1/0 -> exactly 16 beats accepted, identical readout, no extra writes.
- Load sample A (value 16b+j), then sample B (value 256-(16b+j)), no release -> both full. Third start -> WAIT_FREE, dma_ready=0. Release -> index 5 reads 251 (B); LOAD entered the cycle after full clears.
- start pulsed during beat 3 of a load -> start_err one cycle; load_done still after 16 beats.
- gbdt_rst asserted after beat 7 -> next cycle dma_ready=0, sample_valid=0, features_vals=0; a fresh full load then reads correctly.
- FEAT_W=8, DMA_RATE=64, NUM_FEATS=200 (LANES=8, BEATS=25) -> full load reads index 199 correctly; index 200 -> value 0 and idx_err=1 until reset.
